// File: rtl/anahtar_genisletme_if.sv
// Key-expansion bus: key handshake in, round-key bundle and status out.
interface anahtar_genisletme_if;
  logic [127:0]  anahtar;
  logic          g_gecerli;
  logic          hazir;
  logic [1407:0] tur_anahtarlari;
  logic          c_gecerli;

  modport master (
    output anahtar, g_gecerli,
    input  hazir, tur_anahtarlari, c_gecerli
  );

  modport slave (
    input  anahtar, g_gecerli,
    output hazir, tur_anahtarlari, c_gecerli
  );
endinterface

// File: rtl/anahtar_genisletme.sv
// AES-128 key expansion: one round key per cycle, all eleven round keys
// presented together on the bus once c_gecerli rises.
module anahtar_genisletme (
  input logic               clk,
  input logic               rst,
  anahtar_genisletme_if.slave bus
);

  typedef enum logic [1:0] {
    BOS      = 2'd0,
    GENISLET = 2'd1,
    TAMAM    = 2'd2
  } durum_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0x00 sits in the most significant byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  durum_t          durum_q, durum_d;
  logic [3:0]      tur_q, tur_d;
  logic [1407:0]   rk_q, rk_d;
  logic            hazir_q, hazir_d;
  logic            c_gecerli_q, c_gecerli_d;

  logic [127:0]    onceki;
  logic [31:0]     t;
  logic [31:0]     w0, w1, w2, w3;
  logic [127:0]    yeni;

  // Previous round key is selected by the round counter, then one round derived.
  always_comb begin
    onceki = '0;
    for (int r = 1; r <= 10; r++) begin
      if (tur_q == 4'(r)) onceki = rk_q[128*(r-1) +: 128];
    end
    t    = sub_word({onceki[23:0], onceki[31:24]}) ^ {rcon(tur_q), 24'h0};
    w0   = onceki[127:96] ^ t;
    w1   = onceki[95:64]  ^ w0;
    w2   = onceki[63:32]  ^ w1;
    w3   = onceki[31:0]   ^ w2;
    yeni = {w0, w1, w2, w3};
  end

  always_comb begin
    durum_d     = durum_q;
    tur_d       = tur_q;
    rk_d        = rk_q;
    hazir_d     = hazir_q;
    c_gecerli_d = c_gecerli_q;
    case (durum_q)
      BOS, TAMAM: begin
        if (bus.g_gecerli) begin
          rk_d[127:0] = bus.anahtar;
          tur_d       = 4'd1;
          durum_d     = GENISLET;
          hazir_d     = 1'b0;
          c_gecerli_d = 1'b0;
        end
      end
      GENISLET: begin
        for (int r = 1; r <= 10; r++) begin
          if (tur_q == 4'(r)) rk_d[128*r +: 128] = yeni;
        end
        if (tur_q == 4'd10) begin
          durum_d     = TAMAM;
          hazir_d     = 1'b1;
          c_gecerli_d = 1'b1;
        end else begin
          tur_d = tur_q + 4'd1;
        end
      end
      default: begin
        durum_d     = BOS;
        tur_d       = 4'd0;
        hazir_d     = 1'b1;
        c_gecerli_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q     <= BOS;
      tur_q       <= 4'd0;
      rk_q        <= '0;
      hazir_q     <= 1'b1;
      c_gecerli_q <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      tur_q       <= tur_d;
      rk_q        <= rk_d;
      hazir_q     <= hazir_d;
      c_gecerli_q <= c_gecerli_d;
    end
  end

  assign bus.hazir           = hazir_q;
  assign bus.c_gecerli       = c_gecerli_q;
  assign bus.tur_anahtarlari = rk_q;

endmodule
